// File: rtl/chip_test_ctrl.sv
// chip_test_ctrl: bring-up controller sequencing Chip reset, run-cycle watchdog and tohost/halt verdict.
// Optional retired-instruction counter enabled by `define CHIP_TEST_CTRL_RETIRE_CNT_EN.
module chip_test_ctrl #(
    parameter int                 RST_HOLD_CYCLES = 2,
    parameter int                 TIMEOUT_CYCLES  = 100000,
    parameter int                 CNT_W           = 32,
    parameter int                 ADDR_W          = 32,
    parameter int                 DATA_W          = 32,
    parameter logic [ADDR_W-1:0]  TOHOST_ADDR     = 32'h0000_FFF0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              halt,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    input  logic              retire,
    output logic              chip_rst_n,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic              halted,
    output logic [DATA_W-2:0] exit_code,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  retire_cnt
);
    typedef enum logic [1:0] {HOLD, RUN, DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  retire_q, retire_d;
    logic              pass_q, pass_d, fail_q, fail_d;
    logic              timeout_q, timeout_d, halted_q, halted_d;
    logic [DATA_W-2:0] code_q, code_d;
    logic              tohost;

    assign tohost = bus_we && bus_addr == TOHOST_ADDR && bus_wdata != '0;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cycle_d   = cycle_q;
        retire_d  = retire_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;
        halted_d  = halted_q;
        code_d    = code_q;
        case (state_q)
            HOLD: begin
                hold_d  = hold_q == CNT_W'(RST_HOLD_CYCLES - 1) ? '0 : hold_q + 1'b1;
                state_d = hold_q == CNT_W'(RST_HOLD_CYCLES - 1) ? RUN : HOLD;
            end
            RUN: begin
                cycle_d = &cycle_q ? cycle_q : cycle_q + 1'b1;
`ifdef CHIP_TEST_CTRL_RETIRE_CNT_EN
                retire_d = (retire && !(&retire_q)) ? retire_q + 1'b1 : retire_q;
`endif
                if (tohost) begin
                    state_d = DONE;
                    pass_d  = bus_wdata == DATA_W'(1);
                    fail_d  = bus_wdata != DATA_W'(1);
                    code_d  = bus_wdata == DATA_W'(1) ? '0 : bus_wdata[DATA_W-1:1];
                end else if (halt) begin
                    state_d  = DONE;
                    halted_d = 1'b1;
                end else if (cycle_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
            end
            DONE: begin
                if (restart) begin
                    state_d   = HOLD;
                    hold_d    = '0;
                    cycle_d   = '0;
                    retire_d  = '0;
                    pass_d    = 1'b0;
                    fail_d    = 1'b0;
                    timeout_d = 1'b0;
                    halted_d  = 1'b0;
                    code_d    = '0;
                end
            end
            default: state_d = HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HOLD;
            hold_q    <= '0;
            cycle_q   <= '0;
            retire_q  <= '0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
            halted_q  <= 1'b0;
            code_q    <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            cycle_q   <= cycle_d;
            retire_q  <= retire_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
            halted_q  <= halted_d;
            code_q    <= code_d;
        end
    end

`ifndef CHIP_TEST_CTRL_RETIRE_CNT_EN
    logic unused_retire;
    assign unused_retire = retire;
`endif

    // rst_n gates the Chip reset so it drops without waiting for a clock
    assign chip_rst_n = rst_n && state_q != HOLD;
    assign running    = state_q == RUN;
    assign done       = state_q == DONE;
    assign pass       = pass_q;
    assign fail       = fail_q;
    assign timeout    = timeout_q;
    assign halted     = halted_q;
    assign exit_code  = code_q;
    assign cycle_cnt  = cycle_q;
    assign retire_cnt = retire_q;
endmodule

// File: tb/tb_chip_test_ctrl.sv
// tb_chip_test_ctrl: directed bench for chip_test_ctrl (hold=2, timeout=50).
// Retire-count expectation follows CHIP_TEST_CTRL_RETIRE_CNT_EN.
module tb_chip_test_ctrl;
`ifdef CHIP_TEST_CTRL_RETIRE_CNT_EN
    localparam logic [31:0] RET7 = 32'd7;
`else
    localparam logic [31:0] RET7 = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, restart, halt, bus_we, retire;
    logic [31:0] bus_addr, bus_wdata;
    logic        chip_rst_n, running, done, pass, fail, timeout, halted;
    logic [30:0] exit_code;
    logic [31:0] cycle_cnt, retire_cnt;
    int          vectors = 0;
    int          errs = 0;

    chip_test_ctrl #(.RST_HOLD_CYCLES(2), .TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart), .halt(halt),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .retire(retire),
        .chip_rst_n(chip_rst_n), .running(running), .done(done), .pass(pass),
        .fail(fail), .timeout(timeout), .halted(halted), .exit_code(exit_code),
        .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        tick();
        bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_chip_rst0", chip_rst_n, 0);
        tick(2);
        chk("restart_run", {chip_rst_n, running}, 2'b11);
    endtask

    initial begin
        rst_n = 1'b0; restart = 1'b0; halt = 1'b0; bus_we = 1'b0;
        bus_addr = '0; bus_wdata = '0; retire = 1'b1;
        tick(3);
        chk("rst_chip_rst_n", chip_rst_n, 0);
        chk("rst_outputs", {running, done, pass, fail, timeout, halted}, 6'b0);
        chk("rst_counters", {cycle_cnt, retire_cnt}, 64'd0);
        rst_n = 1'b1;
        tick();
        chk("hold_edge1", {chip_rst_n, running}, 2'b00);
        tick();
        chk("hold_edge2", {chip_rst_n, running}, 2'b11);
        chk("run_start_cnt", cycle_cnt, 0);
        chk("hold_retire_ignored", retire_cnt, 0);
        retire = 1'b1;
        tick(7);
        retire = 1'b0;
        chk("retire_cnt_7", retire_cnt, RET7);
        chk("cycle_cnt_7", cycle_cnt, 7);
        wr(32'h0000_FFEC, 32'h1);
        chk("other_addr_ignored", {done, pass}, 2'b00);
        wr(32'h0000_FFF0, 32'h0);
        chk("zero_write_ignored", {done, running}, 2'b01);
        wr(32'h0000_FFF0, 32'h1);
        chk("pass_verdict", {done, pass, fail, timeout, halted, running}, 6'b110000);
        chk("pass_cycle_cnt", cycle_cnt, 10);
        halt = 1'b1; bus_we = 1'b1; bus_addr = 32'h0000_FFF0; bus_wdata = 32'h7;
        tick(3);
        halt = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
        chk("done_sticky", {done, pass, fail, halted}, 4'b1100);
        chk("done_frozen", {cycle_cnt, retire_cnt}, {32'd10, RET7});
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_clear", {done, pass, chip_rst_n, running}, 4'b0000);
        chk("restart_cnt_clear", {cycle_cnt, retire_cnt}, 64'd0);
        tick();
        chk("restart_hold2", chip_rst_n, 0);
        tick();
        chk("restart_run", {chip_rst_n, running}, 2'b11);
        halt = 1'b1;
        wr(32'h0000_FFF0, 32'h7);
        halt = 1'b0;
        chk("fail_verdict", {done, pass, fail, timeout, halted}, 5'b10100);
        chk("fail_exit_code", exit_code, 3);
        chk("fail_cycle_cnt", cycle_cnt, 1);
        do_restart();
        tick(49);
        chk("pre_timeout", {cycle_cnt, 30'd0, done, timeout}, {32'd49, 32'd0});
        tick();
        chk("timeout_verdict", {done, pass, fail, timeout, halted}, 5'b10010);
        chk("timeout_cycle_cnt", cycle_cnt, 50);
        do_restart();
        tick(49);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt_beats_timeout", {done, pass, fail, timeout, halted}, 5'b10001);
        chk("halt_exit_code", exit_code, 0);
        do_restart();
        tick(2);
        chk("pre_abort_cnt", cycle_cnt, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_async", {chip_rst_n, running, done}, 3'b000);
        chk("abort_cnt", {cycle_cnt, retire_cnt}, 64'd0);
        tick();
        rst_n = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/chip_test_ctrl.md
Name: chip_test_ctrl

Overview:
Synthesisable, parametrised simulation/bring-up controller for the Chip top level.
- Sequences the Chip reset release after a programmable hold.
- Counts run cycles and watches a memory-mapped "tohost" store and the CPU halt line.
- Enforces a timeout watchdog and reports a sticky pass/fail/halt/timeout verdict plus exit code.
- Sits beside u_Chip in the simulation top and on FPGA bring-up builds.

Parameters:
RST_HOLD_CYCLES, 2, cycles chip_rst_n is held low after rst_n deasserts (>=1)
TIMEOUT_CYCLES, 100000, run cycles before a timeout verdict (>=1)
CNT_W, 32, width of the cycle and retire counters
ADDR_W, 32, bus address width
DATA_W, 32, bus data width
TOHOST_ADDR, 32'h0000_FFF0, word address monitored for the exit code

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
restart  in  1  single-cycle pulse; re-runs the test from the DONE state
halt  in  1  CPU halt indication from Chip
bus_we  in  1  Chip data-bus write strobe
bus_addr  in  ADDR_W  Chip data-bus address
bus_wdata  in  DATA_W  Chip data-bus write data
retire  in  1  instruction-retired pulse (used only with the optional feature)
chip_rst_n  out  1  reset to Chip, active-low
running  out  1  high while in RUN
done  out  1  sticky verdict valid
pass  out  1  verdict: pass
fail  out  1  verdict: fail
timeout  out  1  verdict: watchdog expired
halted  out  1  verdict: halt with no tohost write
exit_code  out  DATA_W-1  fail code, bus_wdata[DATA_W-1:1]
cycle_cnt  out  CNT_W  cycles spent in RUN
retire_cnt  out  CNT_W  retired instructions

Behaviour:
Reset (rst_n=0, asynchronous):
- State goes to HOLD. chip_rst_n=0 immediately (combinational path from rst_n).
- All other outputs reset to 0; hold counter resets to 0.

States: HOLD, RUN, DONE.

HOLD:
- chip_rst_n=0. Hold counter increments each clk.
- When the counter reaches RST_HOLD_CYCLES-1, go to RUN. chip_rst_n rises synchronously on that edge, so it is low for exactly RST_HOLD_CYCLES clk edges after rst_n rises.
- Bus writes, halt and retire are ignored.

RUN:
- running=1. cycle_cnt increments each cycle; it saturates at all-ones and never wraps.
- Exit conditions, in priority order, evaluated each cycle:
  1. bus_we=1 with bus_addr==TOHOST_ADDR and bus_wdata!=0:
     - bus_wdata==1: pass=1.
     - otherwise: fail=1 and exit_code=bus_wdata[DATA_W-1:1].
  2. halt=1: halted=1.
  3. cycle_cnt==TIMEOUT_CYCLES-1: timeout=1.
- Any exit goes to DONE at the same edge, and done=1 from the next cycle.
- A tohost write of 0 is ignored. Writes to any other address are ignored.
- Simultaneous events resolve by priority: tohost beats halt, halt beats timeout.

DONE:
- Verdict bits are one-hot and sticky. running=0, chip_rst_n=1, counters frozen.
- Further bus writes and halt are ignored.
- restart=1: go to HOLD. This clears done, the verdict bits, exit_code and both counters, and drives chip_rst_n=0 from the next edge.
- restart is ignored in HOLD and RUN.

rst_n mid-operation:
- Asynchronously aborts to HOLD with every output at its reset value.

Latency: verdict is visible 1 cycle after the triggering event.

Optional Feature:
Macro CHIP_TEST_CTRL_RETIRE_CNT_EN.
- Defined: retire_cnt increments on every cycle with retire=1 while in RUN, saturating at all-ones. It is frozen in DONE and cleared by rst_n or restart. A retire pulse on the exit cycle is counted.
- Undefined: the retire input is unused and retire_cnt is tied to 0.

Test Plan:
1. Reset release, RST_HOLD_CYCLES=2: rst_n rises at t0. chip_rst_n must rise exactly on the 2nd clk edge after t0, and running=1 from the same cycle.
2. Pass: in RUN, write 32'h1 to 32'h0000_FFF0 on cycle 10 of RUN. Next cycle: done=1, pass=1, cycle_cnt=10 stays frozen, and a later halt=1 changes nothing.
3. Fail and priority: write 32'h0000_0007 to TOHOST_ADDR with halt=1 in the same cycle. Required: fail=1, exit_code=3, halted=0. A write of 32'h0 or to 32'h0000_FFEC produces no verdict.
4. Timeout: TIMEOUT_CYCLES=50 with no events. Required: timeout=1 after cycle_cnt reaches 49, and done is asserted the following cycle.
5. Restart and abort: pulse restart in DONE. Required: all verdicts clear, chip_rst_n low for 2 cycles, then RUN again. Then drop rst_n mid-RUN: chip_rst_n=0 asynchronously and all outputs return to 0.
6. With CHIP_TEST_CTRL_RETIRE_CNT_EN: 5 retire pulses in HOLD and 7 in RUN give retire_cnt=7. Without the macro, retire_cnt=0 throughout.
